// File: rtl/mult_dispatch_if.sv
// Purpose: bundles the operand stream, result stream, multiplier handshake and
//          accumulator/status signals of mult_dispatch into one port.
// Ports:   slave = dispatcher view, master = surrounding environment view.
interface mult_dispatch_if;
  // operand input stream
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  // result output stream
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_product;
  // multiplier start/done handshake
  logic        mul_start;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_product;
  logic        mul_done;
  // accumulator and status
  logic        acc_clr;
  logic [39:0] acc_value;
  logic [15:0] job_count;
  logic        busy;
  logic        err_clr;
  logic        timeout_err;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_product, mul_done, acc_clr, err_clr,
    output in_ready, out_valid, out_product, mul_start, mul_a, mul_b,
           acc_value, job_count, busy, timeout_err
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, mul_product, mul_done, acc_clr, err_clr,
    input  in_ready, out_valid, out_product, mul_start, mul_a, mul_b,
           acc_value, job_count, busy, timeout_err
  );
endinterface

// File: rtl/mult_dispatch.sv
// Purpose: operand FIFO + start/done sequencer + result register for the 16x16
//          multiplier, with running accumulator, job counter and watchdog flag.
// Latency: push to mul_start is 2 cycles; mul_done to out_valid is 1 cycle.
// Backpressure: in_ready = !full; a full result register parks the FSM in ISSUE.
// Ports:   clk_i, rst_i (synchronous, active-high) and the bus interface (slave).
module mult_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mult_dispatch_if.slave bus
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [15:0] WD_TO = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE
  } state_t;

  state_t state_q, state_d;

  // operand FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [31:0] fifo_mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full;
  logic        push, pop;
  logic        in_ready_w;
  logic [31:0] head;

  logic [15:0] wd_q, wd_d;
  logic [15:0] mul_a_q, mul_a_d;
  logic [15:0] mul_b_q, mul_b_d;
  logic        out_valid_q;
  logic [31:0] out_product_q;
  logic [39:0] acc_q;
  logic [15:0] job_count_q;
  logic        timeout_err_q;
  logic        capture, timeout;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready_w = !rst_i && !fifo_full;
  assign push       = bus.in_valid && in_ready_w;
  assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];

  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_a, bus.in_b};
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    wd_d    = wd_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    case (state_q)
      S_IDLE: begin
        // a stale done from a multiplier that has not yet dropped blocks the start
        if (!fifo_empty && !bus.mul_done) begin
          pop     = 1'b1;
          mul_a_d = head[31:16];
          mul_b_d = head[15:0];
          wd_d    = 16'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.mul_done) begin
          // the result register may be refilled in the same cycle it drains
          if (!out_valid_q || bus.out_ready) begin
            capture = 1'b1;
            state_d = S_RELEASE;
          end
        end else if (wd_q == WD_TO) begin
          timeout = 1'b1;
          state_d = S_RELEASE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_RELEASE: begin
        if (!bus.mul_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wd_q          <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      acc_q         <= '0;
      job_count_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      if (capture) begin
        out_valid_q   <= 1'b1;
        out_product_q <= bus.mul_product;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // clear wins, but a coincident capture still lands in the fresh sum
      if (bus.acc_clr) begin
        acc_q <= capture ? {8'd0, bus.mul_product} : 40'd0;
      end else if (capture) begin
        acc_q <= acc_q + {8'd0, bus.mul_product};
      end

      if (capture) job_count_q <= job_count_q + 16'd1;

      if (timeout) begin
        timeout_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        timeout_err_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;
  assign bus.mul_start   = (state_q == S_ISSUE);
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.acc_value   = acc_q;
  assign bus.job_count   = job_count_q;
  assign bus.busy        = !rst_i && ((state_q != S_IDLE) || !fifo_empty);
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/mult_dispatch.md
# mult_dispatch

Operand-side feeder and result collector for the 16x16 Karatsuba multiplier. It accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. It drives the multiplier's level-held start/done handshake and returns each 32-bit product on a valid/ready output stream. It also keeps a running accumulation, a completed-job count and a sticky watchdog error.

## Interface
- DEPTH, 4: operand FIFO entries; power of two, ≥2.
- TIMEOUT, 255: maximum cycles to wait for `mul_done` in ISSUE; range 1..65535.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; 0 while `rst`, else `!full`.
- in_a, in_b  in  16 each  operands.
- out_valid  out  1  result register full.
- out_ready  in  1  consumer accepts the result.
- out_product  out  32  result.
- mul_start  out  1  multiplier start, level-held.
- mul_a, mul_b  out  16 each  registered operands to the multiplier.
- mul_product  in  32  multiplier result.
- mul_done  in  1  multiplier done; high while its start is held after completion.
- acc_clr  in  1  clear accumulator.
- acc_value  out  40  sum of captured products, modulo 2^40.
- job_count  out  16  captured products, wraps 0xFFFF→0.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- err_clr  in  1  clear `timeout_err`.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- **FIFO:** push on `in_valid && in_ready`. No push when full. No combinational bypass: an entry becomes visible to the FSM the cycle after the push.
- **IDLE:**
  - Waits until the FIFO is non-empty and `mul_done == 0`.
  - Then pops the head, loads `mul_a`/`mul_b`, clears the watchdog counter, and goes to ISSUE.
- **ISSUE:**
  - `mul_start = 1`. `mul_a`/`mul_b` are held stable; the multiplier samples them throughout its run.
  - On `mul_done` with the result register empty, or with it being drained this cycle (`out_valid && out_ready`):
    - capture `mul_product` into `out_product` and set `out_valid`;
    - `acc_value += mul_product` (zero-extended);
    - `job_count += 1`;
    - go to RELEASE.
  - On `mul_done` with the result register full and not draining: stay in ISSUE with `mul_start` held. The multiplier parks with `done` high.
  - Watchdog: counts every ISSUE cycle in which `mul_done == 0`. When the count reaches TIMEOUT:
    - set `timeout_err`;
    - discard the job, with no capture, no accumulate and no count;
    - go to RELEASE.
- **RELEASE:** `mul_start = 0`. Waits for `mul_done == 0`, then goes to IDLE. This guarantees the multiplier has returned to idle before the next start.
- **Result register:** `out_valid` clears on `out_ready`, unless a new capture happens in the same cycle.
- **Accumulator:** `acc_clr` takes priority. If `acc_clr` coincides with a capture, `acc_value` becomes the captured product, not 0.
- **Watchdog flag:** `err_clr` clears `timeout_err`. If it coincides with a new timeout, the flag stays set.
- **Reset:** applies at any time, including mid-job.
  - FSM → IDLE, FIFO emptied.
  - `mul_start`, `out_valid`, `timeout_err`, `busy` = 0.
  - `out_product`, `mul_a`, `mul_b`, `acc_value`, `job_count` = 0.
  - Because `mul_start` drops, the multiplier returns to idle; the next job waits in IDLE until `mul_done == 0`.

## Timing
- Push accepted in cycle T with FSM idle and FIFO empty:
  - FIFO non-empty at T+1; IDLE pops.
  - ISSUE with `mul_start = 1` from T+2.
- `mul_done` first high in cycle D: `out_valid` = 1 and `acc_value`/`job_count` updated at D+1; FSM in RELEASE at D+1.
- RELEASE lasts until `mul_done` falls, normally 1 cycle. The next ISSUE begins no earlier than D+3.
- Throughput: one job per (multiplier latency + 3) cycles when the output is not backpressured.
- `in_ready` is combinational from full. A pop and a push in the same cycle are both allowed; the count is unchanged.
- Watchdog: `timeout_err` rises TIMEOUT+1 cycles after ISSUE entry when `mul_done` never asserts.

## Test plan
- **Single job:** 0x1234 × 0x5678 → `mul_start` rises 2 cycles after the push; `out_product` = 0x06260060, `job_count` = 1, `acc_value` = 0x0006260060.
- **Corner operands:** 0xFFFF × 0xFFFF → 0xFFFE0001, then 0x0000 × 0xABCD → 0. Check `acc_value` = 0x00FFFE0001. `mul_start` must be low for ≥1 cycle between the jobs.
- **FIFO fill and backpressure:**
  - Push DEPTH+2 pairs back-to-back with `out_ready` = 0. `in_ready` falls once full; the FSM parks in ISSUE with `mul_done` high.
  - Raise `out_ready`: all results emerge in order with no loss or duplication.
- **Watchdog:** tie `mul_done` = 0, TIMEOUT = 8 → `timeout_err` rises 9 cycles after ISSUE entry; `out_valid` stays 0; `job_count` unchanged. `err_clr` then clears it.
- **Accumulator clear:** `acc_clr` in the same cycle as capturing 0x00000010, with prior `acc_value` = 0x100 → `acc_value` = 0x10.
- **Reset mid-job:** `rst` pulse during ISSUE → all outputs return to their reset values. A subsequent push of 3 × 5 yields 0x0000000F with `job_count` = 1.
